// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter and its video, CPU-bus and VRAM-macro neighbours.
// master = requesters plus RAM model side, slave = the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [1:0]        ram_be;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din, ram_dout,
    input  vid_data, vid_valid, cpu_dout, cpu_ack, ram_addr, ram_din, ram_we, ram_be
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din, ram_dout,
    output vid_data, vid_valid, cpu_dout, cpu_ack, ram_addr, ram_din, ram_we, ram_be
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: raster fetch owns any slot it asks for (vid_valid exactly 3 cycles after vid_req);
// CPU waits for a free slot and completes with a one-cycle ack (write 2, read 3 cycles after arbitration starts).
module vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {C_IDLE, C_WAIT, C_ISSUE, C_DATA, C_ACK, C_DONE} cpu_state_t;

  cpu_state_t        state, state_nxt;
  logic              cpu_issue;
  logic              cpu_ack;

  logic              lat_we;
  logic [1:0]        lat_be;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [1:0]        ram_be;

  logic              vid_p1, vid_p2;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic [DATA_W-1:0] cpu_dout;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= C_IDLE;
    else          state <= state_nxt;
  end

  // The slot decision is made one cycle ahead of issue: a raster strobe this cycle claims the next slot.
  always_comb begin
    state_nxt = state;
    cpu_issue = 1'b0;
    cpu_ack   = 1'b0;
    case (state)
      C_IDLE:  if (bus.cpu_req) state_nxt = C_WAIT;
      C_WAIT:  if (!bus.vid_req) begin
                 state_nxt = C_ISSUE;
                 cpu_issue = 1'b1;
               end
      C_ISSUE: state_nxt = lat_we ? C_ACK : C_DATA;
      C_DATA:  state_nxt = C_ACK;
      C_ACK:   begin
                 cpu_ack   = 1'b1;
                 state_nxt = C_DONE;
               end
      C_DONE:  if (!bus.cpu_req) state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lat_we   <= 1'b0;
      lat_be   <= 2'b00;
      lat_addr <= '0;
      lat_din  <= '0;
    end else if (state == C_IDLE && bus.cpu_req) begin
      lat_we   <= bus.cpu_we;
      lat_be   <= bus.cpu_be;
      lat_addr <= bus.cpu_addr;
      lat_din  <= bus.cpu_din;
    end
  end

  // Registered RAM command; reads always use both lanes, empty-lane writes never strobe the RAM.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      ram_be   <= 2'b00;
    end else if (bus.vid_req) begin
      ram_addr <= bus.vid_addr;
      ram_we   <= 1'b0;
      ram_be   <= 2'b11;
    end else if (cpu_issue) begin
      ram_addr <= lat_addr;
      ram_din  <= lat_din;
      ram_be   <= lat_we ? lat_be : 2'b11;
      ram_we   <= lat_we & (|lat_be);
    end else begin
      ram_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vid_p1    <= 1'b0;
      vid_p2    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_dout  <= '0;
    end else begin
      vid_p1    <= bus.vid_req;
      vid_p2    <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2)          vid_data <= bus.ram_dout;
      if (state == C_DATA) cpu_dout <= bus.ram_dout;
    end
  end

  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;
  assign bus.ram_we    = ram_we;
  assign bus.ram_be    = ram_be;
  assign bus.vid_data  = vid_data;
  assign bus.vid_valid = vid_valid;
  assign bus.cpu_dout  = cpu_dout;
  assign bus.cpu_ack   = cpu_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: RAM model, scoreboard queues for raster and CPU completions.
module tb_vram_arbiter;
  localparam int ADDR_W = 14;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } vid_exp_t;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    int          cyc;
  } cpu_exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   ack_cnt = 0;
  int   we_cnt  = 0;
  int   w0, a0;

  vid_exp_t    vq[$];
  cpu_exp_t    cq[$];
  logic [15:0] shadow [int];
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  bit          ram_ready = 1'b0;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(16)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int a);
    logic [31:0] t;
    if (a == 32'h0123) return 16'hA5C3;
    t = a * 40503;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] exp_of(input int a);
    if (shadow.exists(a)) return shadow[a];
    return pat(a);
  endfunction

  // Synchronous single-port RAM: read data appears the cycle after the address cycle.
  always @(posedge clk_sys) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (bus.ram_we) begin
      if (bus.ram_be[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
      if (bus.ram_be[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
    end
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push_vid(input logic [15:0] d, input int c);
    vid_exp_t e;
    e.data = d;
    e.cyc  = c;
    vq.push_back(e);
  endtask

  task automatic vid_fetch(input logic [13:0] a);
    bus.vid_req  = 1'b1;
    bus.vid_addr = a;
    push_vid(exp_of(a), cyc + 3);
    tick(1);
    bus.vid_req = 1'b0;
    chk("vid_issue_addr", bus.ram_addr, a);
    chk("vid_issue_we", bus.ram_we, 0);
    chk("vid_issue_be", bus.ram_be, 2'b11);
    tick(3);
  endtask

  task automatic cpu_start(input logic we, input logic [1:0] be, input logic [13:0] a,
                           input logic [15:0] d, input int lat);
    cpu_exp_t e;
    logic [15:0] v;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_be   = be;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    e.rd   = !we;
    e.data = exp_of(a);
    e.cyc  = cyc + lat;
    cq.push_back(e);
    if (we) begin
      v = exp_of(a);
      if (be[0]) v[7:0]  = d[7:0];
      if (be[1]) v[15:8] = d[15:8];
      shadow[a] = v;
    end
  endtask

  task automatic wait_ack(input int budget);
    int start;
    int left;
    start = ack_cnt;
    left  = budget;
    while (ack_cnt == start && left > 0) begin
      tick(1);
      left--;
    end
    chk("ack_seen", (ack_cnt == start) ? 0 : 1, 1);
  endtask

  always @(negedge clk_sys) begin : mon
    vid_exp_t ve;
    cpu_exp_t ce;
    if (reset_n) begin
      if (bus.ram_we) we_cnt++;
      if (bus.vid_valid) begin
        chk("vid_expected", (vq.size() > 0) ? 1 : 0, 1);
        if (vq.size() > 0) begin
          ve = vq.pop_front();
          chk("vid_data", bus.vid_data, ve.data);
          chk("vid_cycle", cyc, ve.cyc);
        end
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        chk("ack_expected", (cq.size() > 0) ? 1 : 0, 1);
        if (cq.size() > 0) begin
          ce = cq.pop_front();
          chk("ack_cycle", cyc, ce.cyc);
          if (ce.rd) chk("cpu_dout", bus.cpu_dout, ce.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h0010;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_be   = 2'b00;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    reset_n      = 1'b0;
    tick(4);
    chk("rst_vid_valid", bus.vid_valid, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_be", bus.ram_be, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    chk("rst_vid_data", bus.vid_data, 0);
    chk("rst_cpu_dout", bus.cpu_dout, 0);

    // First sampled raster strobe is the one present as reset releases.
    bus.cpu_req = 1'b0;
    reset_n     = 1'b1;
    push_vid(exp_of(14'h0010), cyc + 3);
    tick(1);
    bus.vid_req = 1'b0;
    tick(4);

    vid_fetch(14'h0123);

    w0 = we_cnt;
    cpu_start(1'b1, 2'b01, 14'h2000, 16'h12FF, 3);
    tick(2);
    chk("bl_ram_we", bus.ram_we, 1);
    chk("bl_ram_be", bus.ram_be, 2'b01);
    chk("bl_ram_din", bus.ram_din, 16'h12FF);
    chk("bl_ram_addr", bus.ram_addr, 14'h2000);
    wait_ack(10);
    bus.cpu_req = 1'b0;
    chk("bl_we_count", we_cnt - w0, 1);
    tick(1);
    vid_fetch(14'h2000);

    // Four back-to-back raster fetches hold off a waiting CPU read.
    cpu_start(1'b0, 2'b00, 14'h0040, 16'h0000, 8);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      bus.vid_req  = 1'b1;
      bus.vid_addr = 14'h0100 + 14'(i);
      push_vid(exp_of(14'h0100 + i), cyc + 3);
      tick(1);
      chk("ct_vid_issue", bus.ram_addr, 14'h0100 + 14'(i));
    end
    bus.vid_req = 1'b0;
    tick(1);
    chk("ct_cpu_issue_addr", bus.ram_addr, 14'h0040);
    chk("ct_cpu_issue_we", bus.ram_we, 0);
    chk("ct_cpu_issue_be", bus.ram_be, 2'b11);
    wait_ack(12);
    bus.cpu_req = 1'b0;
    tick(1);

    w0 = we_cnt;
    cpu_start(1'b1, 2'b00, 14'h0301, 16'hFFFF, 3);
    wait_ack(10);
    bus.cpu_req = 1'b0;
    chk("be0_no_we", we_cnt - w0, 0);
    tick(1);
    vid_fetch(14'h0301);

    w0 = we_cnt;
    a0 = ack_cnt;
    cpu_start(1'b1, 2'b11, 14'h0300, 16'hBEEF, 3);
    tick(20);
    chk("held_we_count", we_cnt - w0, 1);
    chk("held_ack_count", ack_cnt - a0, 1);
    bus.cpu_req = 1'b0;
    tick(1);
    cpu_start(1'b1, 2'b11, 14'h0300, 16'hCAFE, 3);
    wait_ack(10);
    bus.cpu_req = 1'b0;
    chk("held_second_we", we_cnt - w0, 2);
    tick(1);
    vid_fetch(14'h0300);

    cpu_start(1'b0, 2'b11, 14'h0555, 16'h0000, 4);
    tick(1);
    bus.cpu_req = 1'b0;
    wait_ack(10);
    tick(1);

    // Reset lands in the read's data cycle: the transaction must vanish without an ack.
    a0 = ack_cnt;
    cpu_start(1'b0, 2'b11, 14'h0777, 16'h0000, 4);
    tick(3);
    reset_n     = 1'b0;
    bus.cpu_req = 1'b0;
    cq.delete();
    #1;
    chk("mid_rst_cpu_dout", bus.cpu_dout, 0);
    chk("mid_rst_ram_we", bus.ram_we, 0);
    chk("mid_rst_ram_addr", bus.ram_addr, 0);
    tick(1);
    reset_n = 1'b1;
    tick(4);
    chk("mid_rst_no_ack", ack_cnt - a0, 0);
    cpu_start(1'b0, 2'b11, 14'h0777, 16'h0000, 4);
    wait_ack(10);
    bus.cpu_req = 1'b0;
    tick(5);

    chk("vid_queue_empty", vq.size(), 0);
    chk("cpu_queue_empty", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
